// File: rtl/traffic_sequencer.sv
// traffic_sequencer: registered four-phase traffic light sequencer.
// Emits a Gray-coded phase on o_G and times each phase with an up-counter
// whose limit is chosen by the decoder's long/short trigger feedback.
// Optional feature macro: TRAFFIC_SIDE_SENSOR_EN holds Main-green until
// i_Side_request is seen on a terminal tick.
//
// state | meaning
// ------+--------------------------------
// S0 00 | main road green  (long phase)
// S1 01 | main road yellow (short phase)
// S2 11 | side road green  (long phase)
// S3 10 | side road yellow (short phase)
module traffic_sequencer #(
    parameter int unsigned p_LONG_CYCLES  = 30,
    parameter int unsigned p_SHORT_CYCLES = 5,
    parameter int unsigned p_CNT_W        = 8
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Tick,
    input  logic               i_Long_trigger,
    input  logic               i_Short_trigger,
    input  logic               i_Side_request,
    output logic [1:0]         o_G,
    output logic [p_CNT_W-1:0] o_Count,
    output logic               o_Phase_done,
    output logic               o_Fault
);

    typedef enum logic [1:0] {
        S0_MAIN_GREEN  = 2'b00,
        S1_MAIN_YELLOW = 2'b01,
        S2_SIDE_GREEN  = 2'b11,
        S3_SIDE_YELLOW = 2'b10
    } phase_e;

    // Terminal counts are limit-1 so a limit of 2^p_CNT_W still fits.
    localparam logic [p_CNT_W-1:0] LONG_M1  = p_CNT_W'(p_LONG_CYCLES - 1);
    localparam logic [p_CNT_W-1:0] SHORT_M1 = p_CNT_W'(p_SHORT_CYCLES - 1);

    phase_e             phase_q, phase_d;
    phase_e             phase_next;
    logic [p_CNT_W-1:0] count_q, count_d;
    logic [p_CNT_W-1:0] limit_m1;
    logic               fault_q, fault_d;
    logic               adv_q, adv_d;
    logic               done_q;
    logic               trig_valid;
    logic               advance_ok;

`ifdef TRAFFIC_SIDE_SENSOR_EN
    // Only the Main-green exit waits for a side-road vehicle.
    always_comb begin
        advance_ok = (phase_q != S0_MAIN_GREEN) || i_Side_request;
    end
`else
    logic unused_side_request;
    assign unused_side_request = i_Side_request;

    // Free-running cycle: every terminal tick advances.
    always_comb begin
        advance_ok = 1'b1;
    end
`endif

    // Limit selection from decoder feedback and fixed Gray successor.
    always_comb begin
        trig_valid = i_Long_trigger ^ i_Short_trigger;
        limit_m1   = i_Long_trigger ? LONG_M1 : SHORT_M1;
        case (phase_q)
            S0_MAIN_GREEN:  phase_next = S1_MAIN_YELLOW;
            S1_MAIN_YELLOW: phase_next = S2_SIDE_GREEN;
            S2_SIDE_GREEN:  phase_next = S3_SIDE_YELLOW;
            S3_SIDE_YELLOW: phase_next = S0_MAIN_GREEN;
            default:        phase_next = S0_MAIN_GREEN;
        endcase
    end

    // Next-state: tick-qualified counting, advance, hold and fault handling.
    always_comb begin
        phase_d = phase_q;
        count_d = count_q;
        fault_d = fault_q;
        adv_d   = 1'b0;
        if (i_Tick) begin
            if (!trig_valid) begin
                fault_d = 1'b1;
                count_d = '0;
            end else begin
                fault_d = 1'b0;
                // >= keeps the counter bounded even if the limit shrinks.
                if (count_q >= limit_m1) begin
                    if (advance_ok) begin
                        phase_d = phase_next;
                        count_d = '0;
                        adv_d   = 1'b1;
                    end else begin
                        count_d = limit_m1;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    // State registers; phase_done trails the o_G change by one clock.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            phase_q <= S0_MAIN_GREEN;
            count_q <= '0;
            fault_q <= 1'b0;
            adv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
            fault_q <= fault_d;
            adv_q   <= adv_d;
            done_q  <= adv_q;
        end
    end

    assign o_G          = phase_q;
    assign o_Count      = count_q;
    assign o_Phase_done = done_q;
    assign o_Fault      = fault_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Bench for traffic_sequencer with the light decoder modelled in the loop.
// Long phase = 4 ticks, short phase = 2 ticks.
module tb_traffic_sequencer;

    logic       clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic       i_Tick = 1'b0;
    logic       i_Side_request = 1'b0;
    logic       i_Long_trigger;
    logic       i_Short_trigger;
    logic [1:0] o_G;
    logic [7:0] o_Count;
    logic       o_Phase_done;
    logic       o_Fault;

    // 0: normal decoder, 1: both triggers high, 2: both triggers low
    int force_mode = 0;

    int checks = 0;
    int errors = 0;
    int step_id = 0;

    typedef struct packed {
        logic [1:0] g;
        logic [7:0] cnt;
        logic       done;
        logic       fault;
        int         id;
    } exp_t;

    exp_t exp_q[$];

    // Hand-derived free-run sequence (long=4, short=2), index = cycle mod 12.
    int fr_g   [12] = '{0, 0, 0, 0, 1, 1, 3, 3, 3, 3, 2, 2};
    int fr_cnt [12] = '{0, 1, 2, 3, 0, 1, 0, 1, 2, 3, 0, 1};
    int fr_done[12] = '{0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1};

`ifdef TRAFFIC_SIDE_SENSOR_EN
    logic side_fr = 1'b1;
`else
    logic side_fr = 1'b0;
`endif

    traffic_sequencer #(
        .p_LONG_CYCLES (4),
        .p_SHORT_CYCLES(2),
        .p_CNT_W       (8)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (i_Rst),
        .i_Tick         (i_Tick),
        .i_Long_trigger (i_Long_trigger),
        .i_Short_trigger(i_Short_trigger),
        .i_Side_request (i_Side_request),
        .o_G            (o_G),
        .o_Count        (o_Count),
        .o_Phase_done   (o_Phase_done),
        .o_Fault        (o_Fault)
    );

    always #5 clk = ~clk;

    // Light decoder: green phases (00, 11) are long, yellow (01, 10) short.
    always_comb begin
        i_Long_trigger  = (o_G == 2'b00) || (o_G == 2'b11);
        i_Short_trigger = !i_Long_trigger;
        if (force_mode == 1) begin
            i_Long_trigger  = 1'b1;
            i_Short_trigger = 1'b1;
        end else if (force_mode == 2) begin
            i_Long_trigger  = 1'b0;
            i_Short_trigger = 1'b0;
        end
    end

    // Monitor: after each rising edge, compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({o_G, o_Count, o_Phase_done, o_Fault} !== {e.g, e.cnt, e.done, e.fault}) begin
                    errors++;
                    $display("FAIL step%0d g/cnt/done/fault got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                             e.id, o_G, o_Count, o_Phase_done, o_Fault, e.g, e.cnt, e.done, e.fault);
                end
            end
        end
    end

    // Drive one clock of stimulus and queue the state expected after the edge.
    task automatic cyc(input logic tick, input logic side, input int fmode,
                       input logic [1:0] g, input logic [7:0] cnt,
                       input logic done, input logic fault);
        exp_t e;
        @(negedge clk);
        i_Rst          = 1'b0;
        i_Tick         = tick;
        i_Side_request = side;
        force_mode     = fmode;
        step_id++;
        e.g = g; e.cnt = cnt; e.done = done; e.fault = fault; e.id = step_id;
        exp_q.push_back(e);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic reset_check();
        @(posedge clk);
        #3;
        i_Rst  = 1'b1;
        i_Tick = 1'b0;
        force_mode = 0;
        #1;
        checks++;
        if ({o_G, o_Count, o_Phase_done, o_Fault} !== 12'b0) begin
            errors++;
            $display("FAIL async_reset g/cnt/done/fault got %b/%0d/%b/%b expected 00/0/0/0",
                     o_G, o_Count, o_Phase_done, o_Fault);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        reset_check();

        // Free-run: three periods' worth, stopping in S2 with count 3.
        for (int c = 1; c <= 33; c++)
            cyc(1'b1, side_fr, 0, 2'(fr_g[c % 12]), 8'(fr_cnt[c % 12]),
                (c == 1) ? 1'b0 : fr_done[c % 12][0], 1'b0);

        // Reset mid-S2, then S0 restarts from count 0.
        reset_check();
        for (int c = 1; c <= 5; c++)
            cyc(1'b1, side_fr, 0, 2'(fr_g[c % 12]), 8'(fr_cnt[c % 12]),
                (c == 1) ? 1'b0 : fr_done[c % 12][0], 1'b0);

        // Fault in S1 at count 1: no effect without tick, then set/hold/clear.
        cyc(1'b0, side_fr, 1, 2'b01, 8'd1, 1'b0, 1'b0);
        cyc(1'b1, side_fr, 1, 2'b01, 8'd0, 1'b0, 1'b1);
        cyc(1'b1, side_fr, 2, 2'b01, 8'd0, 1'b0, 1'b1);
        cyc(1'b1, side_fr, 0, 2'b01, 8'd1, 1'b0, 1'b0);
        cyc(1'b1, side_fr, 0, 2'b11, 8'd0, 1'b0, 1'b0);
        cyc(1'b1, side_fr, 0, 2'b11, 8'd1, 1'b1, 1'b0);

        // Tick every third cycle: S0 lasts 12 cycles, done ignores tick.
        reset_check();
        for (int k = 1; k <= 14; k++) begin
            if (k < 12)
                cyc((k % 3) == 0, side_fr, 0, 2'b00, 8'(k / 3), 1'b0, 1'b0);
            else
                cyc((k % 3) == 0, side_fr, 0, 2'b01, 8'd0, k == 13, 1'b0);
        end

`ifdef TRAFFIC_SIDE_SENSOR_EN
        // Sensor hold: Main-green saturates at 3 until a request arrives.
        reset_check();
        for (int k = 1; k <= 13; k++)
            cyc(1'b1, 1'b0, 0, 2'b00, (k < 3) ? 8'(k) : 8'd3, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 0, 2'b01, 8'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 2'b01, 8'd1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 0, 2'b11, 8'd0, 1'b0, 1'b0);
`endif

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending %0d expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
